// File: rtl/rf_read_streamer_pkg.sv
// Shared types and default sizing for the register-file read streamer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_read_streamer_pkg;

  localparam int RS_DATA_WIDTH    = 8;
  localparam int RS_ADDRESS_WIDTH = 5;
  localparam int RS_DATA_DEPTH    = 2 ** RS_ADDRESS_WIDTH;
  // One extra bit so a full-bank count (DATA_DEPTH rows) fits.
  localparam int RS_LEN_WIDTH     = RS_ADDRESS_WIDTH + 1;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_STREAM,
    RS_DRAIN
  } rf_rs_state_t;

endpackage

// File: rtl/rf_read_streamer_if.sv
// Command, bank-read and output-stream bundle for rf_read_streamer.
// Latency: n/a (wires only).
// Backpressure: cmd uses valid/ready, output stream uses valid/ready.
// Optional: RF_READ_STREAMER_LAST_EN adds out_last.
interface rf_read_streamer_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 5,
  parameter int LEN_WIDTH     = ADDRESS_WIDTH + 1
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDRESS_WIDTH-1:0] cmd_base;
  logic [LEN_WIDTH-1:0]     cmd_len;
  logic [ADDRESS_WIDTH-1:0] cmd_stride;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     done;
`ifdef RF_READ_STREAMER_LAST_EN
  logic                     out_last;
`endif

  // Streamer side.
  modport slave (
    input  cmd_valid, cmd_base, cmd_len, cmd_stride, rd_data, out_ready,
    output cmd_ready, rd_addr, out_valid, out_data, done
`ifdef RF_READ_STREAMER_LAST_EN
    , output out_last
`endif
  );

  // Command source / bank / downstream side.
  modport master (
    output cmd_valid, cmd_base, cmd_len, cmd_stride, rd_data, out_ready,
    input  cmd_ready, rd_addr, out_valid, out_data, done
`ifdef RF_READ_STREAMER_LAST_EN
    , input out_last
`endif
  );

endinterface

// File: rtl/rf_read_streamer_pipe_reg.sv
// One-entry valid/ready output register (rf_pipe_reg), parameterised by width.
// Latency: 1 cycle from src accept to dst_vld.
// Backpressure: src_rdy = !dst_vld | dst_rdy; held data is stable while stalled.
module rf_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_vld,
  output logic             src_rdy,
  input  logic [WIDTH-1:0] src_dat,
  output logic             dst_vld,
  input  logic             dst_rdy,
  output logic [WIDTH-1:0] dst_dat
);

  // Accept a new word whenever the slot is empty or is being drained this cycle.
  assign src_rdy = !dst_vld || dst_rdy;

  // Load on accept; otherwise release the slot once downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_vld <= 1'b0;
      dst_dat <= '0;
    end else if (src_vld && src_rdy) begin
      dst_vld <= 1'b1;
      dst_dat <= src_dat;
    end else if (dst_rdy) begin
      dst_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/rf_read_streamer.sv
// Read sequencer for a distributed-RAM register-file bank: base/len/stride command to row stream.
// Latency: first out_valid one edge after the accept edge (accept edge, then capture edge); 1 row/cycle.
// Backpressure: out_ready low freezes capture and address advance; cmd_ready low while busy or during done.
// Optional: RF_READ_STREAMER_LAST_EN adds out_last, flagging the final row of each command.
module rf_read_streamer
  import rf_read_streamer_pkg::*;
#(
  parameter int DATA_WIDTH    = RS_DATA_WIDTH,
  parameter int DATA_DEPTH    = RS_DATA_DEPTH,
  parameter int ADDRESS_WIDTH = RS_ADDRESS_WIDTH,
  parameter int LEN_WIDTH     = ADDRESS_WIDTH + 1
) (
  input  logic                clk,
  input  logic                rst,
  rf_read_streamer_if.slave   bus
);

`ifdef RF_READ_STREAMER_LAST_EN
  localparam int PW = DATA_WIDTH + 1;
`else
  localparam int PW = DATA_WIDTH;
`endif

  rf_rs_state_t             state;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [ADDRESS_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]     remaining;
  logic                     done_q;

  logic                     cmd_fire;
  logic                     cap_vld;
  logic                     cap_rdy;
  logic                     capture;
  logic                     last_row;
  logic [PW-1:0]            cap_dat;
  logic [PW-1:0]            held_dat;
  logic                     held_vld;

  // Blocking cmd_ready during the done cycle keeps done and a new accept apart.
  assign bus.cmd_ready = (state == RS_IDLE) && !done_q;
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign bus.rd_addr   = addr;
  assign bus.done      = done_q;

  assign cap_vld  = (state == RS_STREAM);
  assign capture  = cap_vld && cap_rdy;
  assign last_row = (remaining == LEN_WIDTH'(1));

`ifdef RF_READ_STREAMER_LAST_EN
  assign cap_dat = {last_row, bus.rd_data};
  assign {bus.out_last, bus.out_data} = held_dat;
`else
  assign cap_dat      = bus.rd_data;
  assign bus.out_data = held_dat;
`endif
  assign bus.out_valid = held_vld;

  // Sequencer: command latch, address/count advance per captured row, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RS_IDLE;
      addr      <= '0;
      stride_q  <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RS_IDLE: begin
          if (cmd_fire) begin
            addr      <= bus.cmd_base;
            stride_q  <= bus.cmd_stride;
            remaining <= bus.cmd_len;
            if (bus.cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= RS_STREAM;
            end
          end
        end
        RS_STREAM: begin
          if (capture) begin
            // Natural truncation gives modulo-DATA_DEPTH wrap.
            addr      <= addr + stride_q;
            remaining <= remaining - LEN_WIDTH'(1);
            if (last_row) begin
              state <= RS_DRAIN;
            end
          end
        end
        RS_DRAIN: begin
          if (held_vld && bus.out_ready) begin
            done_q <= 1'b1;
            state  <= RS_IDLE;
          end
        end
        default: state <= RS_IDLE;
      endcase
    end
  end

  rf_pipe_reg #(
    .WIDTH (PW)
  ) u_out_reg (
    .clk     (clk),
    .rst     (rst),
    .src_vld (cap_vld),
    .src_rdy (cap_rdy),
    .src_dat (cap_dat),
    .dst_vld (held_vld),
    .dst_rdy (bus.out_ready),
    .dst_dat (held_dat)
  );

endmodule
